// File: rtl/scr1_ahb_dmem_sram_slv.sv
// scr1_ahb_dmem_sram_slv: AHB-Lite data-memory slave over a sync SRAM with a one-entry posted write buffer
module scr1_ahb_dmem_sram_slv #(
  parameter int          SRAM_AW   = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hsel,
  input  logic [1:0]         htrans,
  input  logic [2:0]         hsize,
  input  logic [31:0]        haddr,
  input  logic               hwrite,
  input  logic [31:0]        hwdata,
  output logic               hready,
  output logic [31:0]        hrdata,
  output logic               hresp,
  output logic               sram_ce,
  output logic               sram_we,
  output logic [3:0]         sram_be,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_wdata,
  input  logic [31:0]        sram_rdata
);
  localparam logic [2:0] DP_IDLE = 3'd0, DP_RD = 3'd1, DP_WR = 3'd2, DP_ERR1 = 3'd3, DP_ERR2 = 3'd4;
  logic [2:0]         state;
  logic [SRAM_AW-1:0] rd_addr_q, wb_addr;
  logic [3:0]         be, be_q, wb_be;
  logic [31:0]        wb_data;
  logic               wb_vld, accept, legal, rd_ap, commit, hit;
  assign hready = rst | (state != DP_ERR1);
  assign hresp = ~rst & (state == DP_ERR1 | state == DP_ERR2);
  assign accept = ~rst & hready & hsel & (htrans == 2'b10 | htrans == 2'b11);
  assign legal = haddr[31:SRAM_AW+2] == BASE_ADDR[31:SRAM_AW+2]
               & (hsize == 3'd0 | hsize == 3'd1 & ~haddr[0] | hsize == 3'd2 & haddr[1:0] == 2'b00);
  assign be = hsize == 3'd0 ? 4'b0001 << haddr[1:0] : hsize == 3'd1 ? 4'b0011 << {haddr[1], 1'b0} : 4'b1111;
  assign rd_ap = accept & legal & ~hwrite;
  assign commit = ~rst & wb_vld & ~rd_ap;
  assign sram_ce = rd_ap | commit;
  assign sram_we = commit;
  assign sram_be = rd_ap ? be : commit ? wb_be : 4'b0000;
  assign sram_addr = rd_ap ? haddr[SRAM_AW+1:2] : commit ? wb_addr : '0;
  assign sram_wdata = commit ? wb_data : 32'h0;
  assign hit = wb_vld & wb_addr == rd_addr_q;
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign hrdata[8*i+:8] = ~rst & state == DP_RD ? (hit & wb_be[i] ? wb_data[8*i+:8] : sram_rdata[8*i+:8]) : 8'h00;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DP_IDLE;
      wb_vld <= 1'b0;
      rd_addr_q <= '0;
      be_q <= 4'b0000;
      wb_addr <= '0;
      wb_be <= 4'b0000;
      wb_data <= 32'h0;
    end else begin
      state <= !hready ? DP_ERR2 : !accept ? DP_IDLE : !legal ? DP_ERR1 : hwrite ? DP_WR : DP_RD;
      if (accept) begin
        rd_addr_q <= haddr[SRAM_AW+1:2];
        be_q <= be;
      end
      if (state == DP_WR) begin
        wb_vld <= 1'b1;
        wb_addr <= rd_addr_q;
        wb_be <= be_q;
        wb_data <= hwdata;
      end else if (commit) begin
        wb_vld <= 1'b0;
      end
      if (state == DP_WR) assert (!(wb_vld && !commit));
    end
  end
endmodule
